// File: rtl/psr_cond_unit.sv
// psr_cond_unit: NZCV status register, condition evaluation with flag forwarding, and a fail counter
module psr_cond_unit #(
   parameter int CNT_W    = 8,
   parameter bit NV_NEVER = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   input  logic             alu_valid,
   input  logic             s_bit,
   input  logic             cv_keep,
   input  logic             instr_valid,
   input  logic [3:0]       cond_in,
   input  logic             stall,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic             cond_pass,
   output logic             pass_valid,
   output logic             carry_out,
   output logic [3:0]       flags_out,
   output logic [CNT_W-1:0] fail_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [3:0] flagsReg;
   logic [3:0] nextFlags;
   logic       flagWe;
   logic       condOk;
   logic       n, z, c, v;
   assign flagWe    = alu_valid & s_bit & cond_pass & pass_valid & !stall;
   assign flags_out = flagsReg;
   assign carry_out = flagsReg[1];
   assign {n, z, c, v} = nextFlags;
   // flags about to be written this edge, so a dependent condition needs no bubble
   always_comb nextFlags = flagWe ? {alu_n, alu_z, cv_keep ? flagsReg[1:0] : {alu_c, alu_v}} : flagsReg;
   // evaluate the decode-stage condition field against the forwarded flags
   always_comb begin
      condOk = 1'b0;
      case (cond_in)
         4'b0000: condOk = z;
         4'b0001: condOk = !z;
         4'b0010: condOk = c;
         4'b0011: condOk = !c;
         4'b0100: condOk = n;
         4'b0101: condOk = !n;
         4'b0110: condOk = v;
         4'b0111: condOk = !v;
         4'b1000: condOk = c & !z;
         4'b1001: condOk = !c | z;
         4'b1010: condOk = n == v;
         4'b1011: condOk = n != v;
         4'b1100: condOk = !z & (n == v);
         4'b1101: condOk = z | (n != v);
         4'b1110: condOk = 1'b1;
         default: condOk = !NV_NEVER;
      endcase
   end
   // status register, decode-to-execute pipeline stage and saturating fail counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flagsReg   <= '0;
         cond_pass  <= 1'b0;
         pass_valid <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         if (flagWe) flagsReg <= nextFlags;
         if (!stall) begin
            pass_valid <= !flush & instr_valid;
            cond_pass  <= !flush & instr_valid & condOk;
         end
         if (cnt_clr) fail_cnt <= '0;
         else if (!stall && !flush && instr_valid && !condOk && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_psr_cond_unit.sv
// tb_psr_cond_unit: directed and randomized checks of psr_cond_unit against a behavioural model
module tb_psr_cond_unit;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic alu_n = 0, alu_z = 0, alu_c = 0, alu_v = 0, alu_valid = 0, s_bit = 0, cv_keep = 0;
   logic instr_valid = 0, stall = 0, flush = 0, cnt_clr = 0;
   logic [3:0] cond_in = 4'b1110;
   logic cond_pass, pass_valid, carry_out;
   logic [3:0] flags_out;
   logic [CNT_W-1:0] fail_cnt;
   int tests = 0;
   int failed = 0;
   bit mN, mZ, mC, mV, mPass, mValid;
   int mCnt;

   psr_cond_unit #(.CNT_W(CNT_W), .NV_NEVER(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
      .alu_valid(alu_valid), .s_bit(s_bit), .cv_keep(cv_keep),
      .instr_valid(instr_valid), .cond_in(cond_in),
      .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .cond_pass(cond_pass), .pass_valid(pass_valid), .carry_out(carry_out),
      .flags_out(flags_out), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ARM encoding: odd codes are the negation of the even code below them
   function automatic bit condHolds(input logic [3:0] c, input bit n, input bit z, input bit cy, input bit v);
      bit r;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cy;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cy && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      return c[0] ? !r : r;
   endfunction

   task automatic checkAll(input string tag);
      checkVal({tag, ".flags"}, flags_out, {mN, mZ, mC, mV});
      checkVal({tag, ".carry"}, carry_out, mC);
      checkVal({tag, ".pass"}, cond_pass, mPass);
      checkVal({tag, ".valid"}, pass_valid, mValid);
      checkVal({tag, ".cnt"}, fail_cnt, mCnt);
   endtask

   // one clock: predict from pre-edge state and inputs, then compare after the edge
   task automatic cycle(input string tag);
      bit we, fn, fz, fc, fv, ok;
      we = alu_valid && s_bit && mPass && mValid && !stall;
      fn = we ? alu_n : mN;
      fz = we ? alu_z : mZ;
      fc = (we && !cv_keep) ? alu_c : mC;
      fv = (we && !cv_keep) ? alu_v : mV;
      ok = condHolds(cond_in, fn, fz, fc, fv);
      @(posedge clk);
      {mN, mZ, mC, mV} = {fn, fz, fc, fv};
      if (!stall) begin
         mValid = !flush && instr_valid;
         mPass  = !flush && instr_valid && ok;
      end
      if (cnt_clr) mCnt = 0;
      else if (!stall && !flush && instr_valid && !ok && mCnt < CNT_MAX) mCnt++;
      #1;
      checkAll(tag);
   endtask

   task automatic setIn(input bit av, input bit s, input bit keep, input logic [3:0] nzcv,
                        input bit iv, input logic [3:0] c, input bit st, input bit fl, input bit clr);
      alu_valid = av; s_bit = s; cv_keep = keep; {alu_n, alu_z, alu_c, alu_v} = nzcv;
      instr_valid = iv; cond_in = c; stall = st; flush = fl; cnt_clr = clr;
   endtask

   task automatic modelReset();
      {mN, mZ, mC, mV} = 4'b0;
      mPass = 0; mValid = 0; mCnt = 0;
   endtask

   initial begin
      modelReset();
      #12 rst_n = 1'b1;
      #1 checkAll("reset");
      @(negedge clk);
      setIn(0, 0, 0, 4'h0, 1, 4'b1110, 0, 0, 0); cycle("al");
      setIn(1, 1, 0, 4'b0100, 1, 4'b0000, 0, 0, 0); cycle("fwd_eq");
      checkVal("fwd_eq.pass_c", cond_pass, 1);
      checkVal("fwd_eq.flags_c", flags_out, 4'b0100);
      setIn(1, 1, 0, 4'b0000, 1, 4'b1110, 0, 0, 0); cycle("al2");
      setIn(1, 1, 0, 4'b0000, 1, 4'b0000, 0, 0, 0); cycle("fwd_ne");
      checkVal("fwd_ne.pass_c", cond_pass, 0);
      checkVal("fwd_ne.cnt_c", fail_cnt, 1);
      setIn(0, 0, 0, 4'h0, 1, 4'b1110, 0, 0, 0); cycle("al3");
      setIn(1, 1, 0, 4'b0011, 1, 4'b1110, 0, 0, 0); cycle("set0011");
      setIn(1, 1, 1, 4'b1000, 1, 4'b1010, 0, 0, 0); cycle("cvkeep_ge");
      checkVal("cvkeep.flags_c", flags_out, 4'b1011);
      checkVal("cvkeep.carry_c", carry_out, 1);
      checkVal("cvkeep.ge_c", cond_pass, 1);
      setIn(0, 0, 0, 4'h0, 1, 4'b1100, 0, 0, 0); cycle("gt");
      checkVal("gt.pass_c", cond_pass, 1);
      setIn(0, 0, 0, 4'h0, 1, 4'b0000, 0, 0, 0); cycle("eq_fail");
      setIn(1, 1, 0, 4'b0101, 1, 4'b1110, 0, 0, 0); cycle("gated");
      checkVal("gated.flags_c", flags_out, 4'b1011);
      setIn(1, 1, 0, 4'b0110, 1, 4'b0001, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle("stall");
      checkVal("stall.flags_c", flags_out, 4'b1011);
      setIn(1, 1, 0, 4'b0110, 1, 4'b1111, 0, 1, 0); cycle("flush");
      checkVal("flush.valid_c", pass_valid, 0);
      checkVal("flush.flags_c", flags_out, 4'b0110);
      setIn(0, 0, 0, 4'h0, 1, 4'b1111, 0, 0, 0); cycle("nv");
      checkVal("nv.pass_c", cond_pass, 0);
      setIn(0, 0, 0, 4'h0, 1, 4'b1110, 0, 0, 0); cycle("al4");
      checkVal("al4.pass_c", cond_pass, 1);
      rst_n = 1'b0; #2;
      modelReset();
      checkAll("async_rst");
      checkVal("async_rst.flags_c", flags_out, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      setIn(0, 0, 0, 4'h0, 1, 4'b1111, 0, 0, 0);
      for (int i = 0; i < 260; i++) cycle("sat");
      checkVal("sat.cnt_c", fail_cnt, CNT_MAX);
      cycle("sat_hold");
      setIn(0, 0, 0, 4'h0, 1, 4'b1111, 0, 0, 1); cycle("clr");
      checkVal("clr.cnt_c", fail_cnt, 0);
      for (int i = 0; i < 3000; i++) begin
         setIn($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0, 4'($urandom),
               $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
         cycle("rand");
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/psr_cond_unit.md
Name: psr_cond_unit

Overview:
- Consumer end of the ALU flag interface. Latches N/Z/C/V from the ALU into the status register on S-suffixed instructions.
- Evaluates the 4-bit ARM condition field of the next instruction against the current (or forwarded) flags.
- Returns the registered carry to the ALU carry input.
- Sits between decode and execute. It also keeps a saturating count of condition-failed instructions for debug.

Parameters:
- CNT_W, 8, width of the failed-condition counter.
- NV_NEVER, 1, 1: cond 1111 always fails (ARMv4 NV); 0: cond 1111 always passes.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_n, alu_z, alu_c, alu_v  in  1 each  flag outputs of ALU for instruction in execute
- alu_valid  in  1  ALU result/flags valid this cycle
- s_bit  in  1  execute-stage instruction requests flag update
- cv_keep  in  1  execute-stage op is logical/move: C and V retain old value
- instr_valid  in  1  decode-stage instruction present
- cond_in  in  4  decode-stage condition field
- stall  in  1  pipeline hold
- flush  in  1  discard decode-stage instruction
- cnt_clr  in  1  synchronous clear of fail counter
- cond_pass  out  1  registered: execute-stage instruction passed its condition
- pass_valid  out  1  registered: cond_pass refers to a real instruction
- carry_out  out  1  C bit of status register, to ALU carry input
- flags_out  out  4  status register {N,Z,C,V}
- fail_cnt  out  CNT_W  saturating count of failed conditions

Behaviour:
- Reset (rst_n=0, asynchronous): flags_out=0000, carry_out=0, cond_pass=0, pass_valid=0, fail_cnt=0. Takes effect immediately, mid-instruction included. The first edge after release behaves normally.
- Flag write (flag_we): alu_valid & s_bit & cond_pass & pass_valid & !stall.
  - On the edge, N<=alu_n and Z<=alu_z.
  - C<=alu_c and V<=alu_v only if cv_keep=0; otherwise C and V hold.
- Forwarding: condition evaluation uses next-flags.
  - When flag_we=1 in a cycle, the NZCV about to be written (after cv_keep masking) are used.
  - Otherwise the register value is used.
  - A back-to-back SUBS then BEQ therefore resolves with zero bubbles.
- Condition table (c = cond_in):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 per NV_NEVER
- Pipeline register, 1-cycle latency. On each edge, in priority order:
  1. stall=1: cond_pass and pass_valid hold; no flag write; fail_cnt holds.
  2. flush=1 (and stall=0): pass_valid<=0, cond_pass<=0.
  3. Otherwise: pass_valid<=instr_valid, cond_pass<=instr_valid & eval(cond_in).
- Flush affects only the decode-stage instruction. The concurrent execute-stage flag write still occurs.
- carry_out equals the registered C and changes only on the edge after flag_we.
- fail_cnt:
  - Increments on an edge with instr_valid=1, eval=0, stall=0, flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over increment and sets fail_cnt to 0.
- alu_valid=1 with s_bit=0, or with cond_pass=0: flags unchanged.
- Flag inputs are don't-care when flag_we=0.
- No state machine beyond the pipeline register. All outputs are registered except the internal next-flags forwarding path.

Test Plan:
- Reset: drive flags_out via writes, assert rst_n=0 between edges -> all outputs 0 immediately, before the next edge.
- Forwarded EQ: cycle 0 flag_we with alu_z=1, same cycle instr_valid, cond_in=0000 -> cycle 1 cond_pass=1, pass_valid=1, flags_out=0100. Repeat with alu_z=0 -> cond_pass=0, fail_cnt=1.
- cv_keep: flags 0011, write alu_n=1, alu_z=0, alu_c=0, alu_v=0, cv_keep=1 -> flags_out=1011, carry_out=1. Then GE (1010) -> pass; GT (1100) -> pass.
- Gating: cond_pass=0 with alu_valid=1, s_bit=1 -> flags unchanged. Stall=1 for 3 cycles during a flag_we -> cond_pass/pass_valid/flags/fail_cnt held throughout.
- Flush and NV: flush=1 with instr_valid=1 -> next pass_valid=0, and an execute-stage write in the same cycle still updates flags. NV_NEVER=1 with cond 1111 -> cond_pass=0; AL 1110 -> cond_pass=1.
- Counter: CNT_W=8, issue 260 failing instructions -> fail_cnt=255, holds. Assert cnt_clr together with a failing instruction -> fail_cnt=0.
